data_ram_arbiter: RTL
=====================

// Module: data_ram_arbiter
// PURPOSE
//  Shares one data_ram-style memory slave (cs/we/addr/din -> dout/stall) between two requesters.
//  Typical hookup: m0 = CPU MEM stage, m1 = DMA/debug port.
//  Round-robin grant with one transaction in flight and one idle (cs-low) recovery cycle after
//  each transaction, so the slave's access counter restarts.
//  Watchdog aborts a slave that stalls too long.
// PARAMETERS
//  ADDR_W      32   address width on all ports
//  DATA_W      32   data width on all ports
//  TIMEOUT     64   max cycles in BUSY before abort; legal range 9..1023
//  CNT_W       10   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  m0_cs      in   1       requester 0 access request; held until its stall is low
//  m0_we      in   1       requester 0 write enable
//  m0_addr    in   ADDR_W  requester 0 address
//  m0_din     in   DATA_W  requester 0 write data
//  m0_dout    out  DATA_W  requester 0 read data; valid only on its completion cycle, else 0
//  m0_stall   out  1       requester 0 wait
//  m1_*       --   --      identical set for requester 1
//  mem_cs     out  1       to slave cs
//  mem_we     out  1       to slave we
//  mem_addr   out  ADDR_W  to slave addr
//  mem_din    out  DATA_W  to slave din
//  mem_dout   in   DATA_W  from slave
//  mem_stall  in   1       from slave
//  err        out  1       one-cycle pulse: watchdog abort
//  err_id     out  1       requester aborted; held until next abort
// BEHAVIOUR
//  Reset (sync, active-high):
//   - state=IDLE, grant=0, last=1 (m0 wins first tie), wdog=0, err=0, err_id=0.
//   - mem_cs=0; mem_we/addr/din=0; all mX_dout=0.
//  Stall rule: mX_stall = mX_cs & ~done_X, always, including during reset.
//   - done_X = (state==BUSY) & grant==X & ~mem_stall, or the watchdog abort cycle for X.
//  FSM:
//   - IDLE: no cs -> stay.
//     - One cs -> latch grant, go BUSY.
//     - Both cs -> grant = ~last, go BUSY.
//     - Grant is decided from registered state; no combinational cs->grant path to the mem.
//   - BUSY: mem_cs=1; mem_we/addr/din pass through combinationally from the granted requester;
//     wdog increments.
//     - mem_stall=0: mem_dout goes to the granted mX_dout, done_X for that cycle, last=grant,
//       go RECOVER.
//     - Granted mX_cs drops (protocol violation): abandon, no done/err, go RECOVER.
//     - wdog==TIMEOUT-1 with mem_stall=1: abort.
//       - done_X with mX_dout=0, err=1, err_id=grant, last=grant, go RECOVER.
//       - Requester sees completion with zero data and must consult err.
//   - RECOVER: mem_cs=0 for exactly one cycle; wdog=0; go IDLE.
//     - Turnaround: 2 idle cycles per transaction; the requester may reassert cs on the cycle
//       after done.
//  Outputs outside BUSY: mem_we/addr/din=0; non-granted mX_dout=0 at all times.
//  Fairness: a requester holding cs continuously is served within one foreign transaction.
//  Simultaneous done and rst: rst wins; the transaction is lost.
//   - Requester re-issues, since its stall stays high.
//  Width rules: no width conversion; addresses and data pass through unmodified.
// STRUCTURE
//  mem_arb_defs.vh (shared include): localparams S_IDLE=2'd0, S_BUSY=2'd1, S_RECOVER=2'd2;
//  default TIMEOUT.
//  Sub-module rr_pick2: inputs req[1:0], last -> outputs gnt, any.
//   - Purely combinational; reused by the future I/D-cache arbiter.
//  Top level: FSM, watchdog counter, output muxes.
// TESTING (bench drives mem_* from a data_ram model, 8-negedge ACK latency)
//  1. rst, then m0 read addr 0x4 (preloaded 0xDEADBEEF):
//     -> mem_cs 1 for the slave's latency, m0_stall high until done, m0_dout=0xDEADBEEF
//        exactly one cycle, mem_cs low next cycle.
//  2. m1 write 0x8<=0x12345678, then m1 read 0x8 -> read returns 0x12345678; 2-cycle gap
//     between mem_cs pulses.
//  3. m0 and m1 cs asserted same cycle after reset, both held:
//     -> m0 served first, then m1, then m0; grants strictly alternate.
//  4. Slave model ties mem_stall=1, TIMEOUT=16:
//     -> done at BUSY cycle 16, dout=0, err pulse 1 cycle, err_id=grant, next request still served.
//  5. rst asserted mid-BUSY:
//     -> next cycle mem_cs=0, state IDLE, mX_stall follows cs; re-issued request completes normally.
//  6. m1 drops cs mid-BUSY:
//     -> mem_cs low next cycle, no err, m0's pending request granted after RECOVER.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data_ram arbiter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and the default watchdog limit.
package data_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RECOVER = 2'd2
    } arb_state_t;

    // Cycles a slave may stall in BUSY before the transaction is aborted.
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/data_ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: the requester that did not win last time wins a tie.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
// Ports: req[1:0] requests, last = previous winner, gnt = chosen index, any = some request.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        if (&req) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one data_ram-style slave between two requesters, round-robin, one transaction in flight.
// Latency: request seen in IDLE -> slave cs next cycle; completion follows slave stall; 2 idle cycles after each.
// Backpressure: mX_stall held while the requester's cs is up and its transaction has not completed.
// Ports: clk/rst; m0_*/m1_* requester side (cs, we, addr, din, dout, stall);
//        mem_* slave side (cs, we, addr, din, dout, stall); err pulse and err_id on watchdog abort.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_cs,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m0_dout,
    output logic              m0_stall,

    input  logic              m1_cs,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    output logic [DATA_W-1:0] m1_dout,
    output logic              m1_stall,

    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_stall,

    output logic              err,
    output logic              err_id
);

    arb_state_t       state, state_nxt;
    logic             grant, grant_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] wdog, wdog_nxt;
    logic             err_nxt, err_id_nxt;

    logic             pick_gnt, pick_any;
    logic             busy, g_cs, g_we, wdog_hit, complete, abort, finish;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_din;

    // Pick is only taken in IDLE and registered into grant, so cs never
    // reaches the slave port combinationally.
    rr_pick2 u_pick (
        .req  ({m1_cs, m0_cs}),
        .last (last),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    assign g_cs   = grant ? m1_cs   : m0_cs;
    assign g_we   = grant ? m1_we   : m0_we;
    assign g_addr = grant ? m1_addr : m0_addr;
    assign g_din  = grant ? m1_din  : m0_din;

    // Reset overrides an in-flight completion: the requester keeps stalling
    // and re-issues once the arbiter is back in IDLE.
    assign busy     = (state == S_BUSY) & ~rst;
    assign wdog_hit = (wdog == CNT_W'(TIMEOUT - 1));
    assign complete = busy & g_cs & ~mem_stall;
    assign abort    = busy & g_cs & mem_stall & wdog_hit;
    assign finish   = complete | abort;

    assign mem_cs   = busy;
    assign mem_we   = busy & g_we;
    assign mem_addr = busy ? g_addr : '0;
    assign mem_din  = busy ? g_din  : '0;

    // An aborted transaction completes with zero data; err tells them apart.
    assign m0_dout  = (complete & ~grant) ? mem_dout : '0;
    assign m1_dout  = (complete &  grant) ? mem_dout : '0;
    assign m0_stall = m0_cs & ~(finish & ~grant);
    assign m1_stall = m1_cs & ~(finish &  grant);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        last_nxt   = last;
        wdog_nxt   = wdog;
        err_nxt    = 1'b0;
        err_id_nxt = err_id;
        case (state)
            S_IDLE: begin
                wdog_nxt = '0;
                if (pick_any) begin
                    grant_nxt = pick_gnt;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                wdog_nxt = wdog + 1'b1;
                if (!g_cs) begin
                    // Requester walked away mid-transaction: drop it silently.
                    state_nxt = S_RECOVER;
                end else if (finish) begin
                    last_nxt  = grant;
                    state_nxt = S_RECOVER;
                    if (abort) begin
                        err_nxt    = 1'b1;
                        err_id_nxt = grant;
                    end
                end
            end
            S_RECOVER: begin
                // One cs-low cycle lets the slave restart its access counter.
                wdog_nxt  = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                wdog_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            grant  <= 1'b0;
            last   <= 1'b1;
            wdog   <= '0;
            err    <= 1'b0;
            err_id <= 1'b0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            last   <= last_nxt;
            wdog   <= wdog_nxt;
            err    <= err_nxt;
            err_id <= err_id_nxt;
        end
    end

endmodule
